// File: rtl/writeback_redirect_pkg.sv
// Shared uop encodings, uop class masks and writeback FSM state encoding.
// The HALT state only exists when WB_MISALIGN_TRAP_EN is defined.
package writeback_redirect_pkg;

   localparam logic [5:0] UOP_ADD   = 6'o00;
   localparam logic [5:0] UOP_SRAI  = 6'o32;
   localparam logic [5:0] UOP_BEQ   = 6'o30;
   localparam logic [5:0] UOP_BNE   = 6'o31;
   localparam logic [5:0] UOP_BLT   = 6'o34;
   localparam logic [5:0] UOP_BGE   = 6'o35;
   localparam logic [5:0] UOP_BLTU  = 6'o36;
   localparam logic [5:0] UOP_BGEU  = 6'o37;
   localparam logic [5:0] UOP_AUIPC = 6'o40;
   localparam logic [5:0] UOP_JAL   = 6'o41;
   localparam logic [5:0] UOP_JALR  = 6'o42;

   // One bit per uop encoding: bit n set means uop n belongs to the class.
   localparam logic [63:0] WRITE_MASK  = 64'h0000_0007_04FF_30FF;
   localparam logic [63:0] BRANCH_MASK = 64'h0000_0000_F300_0000;
   localparam logic [63:0] JUMP_MASK   = 64'h0000_0006_0000_0000;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SQUASH = 2'd1
`ifdef WB_MISALIGN_TRAP_EN
      ,
      ST_HALT   = 2'd2
`endif
   } wb_state_e;

endpackage

// File: rtl/writeback_redirect_wb_uop_decode.sv
// Combinational uop classifier: write, branch and jump class membership.
module wb_uop_decode
   import writeback_redirect_pkg::*;
#(
   parameter int W_PD_UOPS = 6
) (
   input  logic [W_PD_UOPS-1:0] uops_i,
   output logic                 is_write_o,
   output logic                 is_branch_o,
   output logic                 is_jump_o
);

   assign is_write_o  = WRITE_MASK[uops_i];
   assign is_branch_o = BRANCH_MASK[uops_i];
   assign is_jump_o   = JUMP_MASK[uops_i];

endmodule

// File: rtl/writeback_redirect.sv
// Writeback stage: register-file write, front-end redirect, wrong-path squash, retire count.
// Optional misaligned-target trap and HALT state enabled by WB_MISALIGN_TRAP_EN.
//
// state  | meaning
// RUN    | accepting presented instructions
// SQUASH | discarding SQUASH_DEPTH cycles after a redirect
// HALT   | misaligned-target trap taken, everything discarded until rst
module writeback_redirect
   import writeback_redirect_pkg::*;
#(
   parameter int W_AA_INSTR   = 32,
   parameter int W_PD_DATA    = 32,
   parameter int W_PD_UOPS    = 6,
   parameter int W_PD_REGIDX  = 5,
   parameter int SQUASH_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   DFI_PD_valid,
   input  logic [W_PD_UOPS-1:0]   DFI_PD_uops,
   input  logic [W_PD_REGIDX-1:0] DFI_PD_rdIdx,
   input  logic [W_AA_INSTR-1:0]  DFI_AA_pc,
   input  logic [W_PD_DATA-1:0]   DFI_PD_rd1,
   input  logic [W_AA_INSTR-1:0]  DFI_AA_br,
   output logic                   DFO_PD_wrEn,
   output logic [W_PD_REGIDX-1:0] DFO_PD_wrIdx,
   output logic [W_PD_DATA-1:0]   DFO_PD_wrData,
   output logic                   DFO_AA_redirect,
   output logic [W_AA_INSTR-1:0]  DFO_AA_target,
   output logic                   DFO_PD_squash,
   output logic                   DFO_PD_exc,
   output logic [31:0]            DFO_PD_retired
);

   localparam logic [2:0] SQ_LOAD = 3'(SQUASH_DEPTH);

   logic is_write, is_branch, is_jump;
   logic taken, trap;
   logic [W_AA_INSTR-1:0] seq_pc;

   wb_state_e              state_q, state_d;
   logic [2:0]             sq_cnt_q, sq_cnt_d;
   logic [31:0]            retired_q, retired_d;
   logic                   wr_en_q, wr_en_d;
   logic [W_PD_REGIDX-1:0] wr_idx_q, wr_idx_d;
   logic [W_PD_DATA-1:0]   wr_data_q, wr_data_d;
   logic                   redirect_q, redirect_d;
   logic [W_AA_INSTR-1:0]  target_q, target_d;
   logic                   exc_q, exc_d;

   wb_uop_decode #(.W_PD_UOPS(W_PD_UOPS)) u_decode (
      .uops_i      (DFI_PD_uops),
      .is_write_o  (is_write),
      .is_branch_o (is_branch),
      .is_jump_o   (is_jump)
   );

   assign seq_pc = DFI_AA_pc + W_AA_INSTR'(4);
   assign taken  = is_jump || (is_branch && (DFI_AA_br != seq_pc));

`ifdef WB_MISALIGN_TRAP_EN
   assign trap = taken && (DFI_AA_br[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      sq_cnt_d   = sq_cnt_q;
      retired_d  = retired_q;
      wr_en_d    = 1'b0;
      wr_idx_d   = '0;
      wr_data_d  = '0;
      redirect_d = 1'b0;
      target_d   = '0;
      exc_d      = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (DFI_PD_valid) begin
               if (trap) begin
                  exc_d = 1'b1;
`ifdef WB_MISALIGN_TRAP_EN
                  state_d = ST_HALT;
`endif
               end else begin
                  retired_d = retired_q + 32'd1;
                  if (is_write && (DFI_PD_rdIdx != '0)) begin
                     wr_en_d   = 1'b1;
                     wr_idx_d  = DFI_PD_rdIdx;
                     wr_data_d = DFI_PD_rd1;
                  end
                  if (taken) begin
                     redirect_d = 1'b1;
                     target_d   = {DFI_AA_br[W_AA_INSTR-1:2], 2'b00};
                     state_d    = ST_SQUASH;
                     sq_cnt_d   = SQ_LOAD;
                  end
               end
            end
         end
         ST_SQUASH: begin
            // Counts down regardless of valid; leaves on the edge it hits zero.
            sq_cnt_d = sq_cnt_q - 3'd1;
            if (sq_cnt_q == 3'd1) state_d = ST_RUN;
         end
`ifdef WB_MISALIGN_TRAP_EN
         ST_HALT: ;
`endif
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         sq_cnt_q   <= '0;
         retired_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_idx_q   <= '0;
         wr_data_q  <= '0;
         redirect_q <= 1'b0;
         target_q   <= '0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sq_cnt_q   <= sq_cnt_d;
         retired_q  <= retired_d;
         wr_en_q    <= wr_en_d;
         wr_idx_q   <= wr_idx_d;
         wr_data_q  <= wr_data_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
         exc_q      <= exc_d;
      end
   end

   assign DFO_PD_wrEn     = wr_en_q;
   assign DFO_PD_wrIdx    = wr_idx_q;
   assign DFO_PD_wrData   = wr_data_q;
   assign DFO_AA_redirect = redirect_q;
   assign DFO_AA_target   = target_q;
   assign DFO_PD_squash   = (state_q == ST_SQUASH);
   assign DFO_PD_exc      = exc_q;
   assign DFO_PD_retired  = retired_q;

endmodule

// File: tb/tb_writeback_redirect.sv
// Self-checking bench for writeback_redirect: directed scenarios plus randomized
// traffic against a cycle-level behavioural model (WB_MISALIGN_TRAP_EN aware).
module tb_writeback_redirect;

   localparam int D = 2;
`ifdef WB_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [5:0] U_ADD = 6'o00, U_BEQ = 6'o30, U_BNE = 6'o31, U_AUIPC = 6'o40,
                          U_JAL = 6'o41, U_JALR = 6'o42;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [5:0]  uops;
   logic [4:0]  rd_idx;
   logic [31:0] pc, rd1, br;
   logic        wr_en, redirect, squash, exc;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data, target, retired;

   int errors = 0;
   int checks = 0;

   // behavioural model state and expected outputs
   int          m_sq;
   bit          m_halt;
   logic [31:0] m_ret;
   bit          e_wren, e_redir, e_exc, e_squash;
   logic [4:0]  e_wridx;
   logic [31:0] e_wrdata, e_target;

   writeback_redirect #(
      .W_AA_INSTR(32), .W_PD_DATA(32), .W_PD_UOPS(6), .W_PD_REGIDX(5), .SQUASH_DEPTH(D)
   ) dut (
      .clk(clk), .rst(rst),
      .DFI_PD_valid(valid), .DFI_PD_uops(uops), .DFI_PD_rdIdx(rd_idx),
      .DFI_AA_pc(pc), .DFI_PD_rd1(rd1), .DFI_AA_br(br),
      .DFO_PD_wrEn(wr_en), .DFO_PD_wrIdx(wr_idx), .DFO_PD_wrData(wr_data),
      .DFO_AA_redirect(redirect), .DFO_AA_target(target),
      .DFO_PD_squash(squash), .DFO_PD_exc(exc), .DFO_PD_retired(retired)
   );

   always #5 clk = ~clk;

   function automatic bit is_wr(input logic [5:0] u);
      return u inside {[6'o00:6'o07], 6'o14, 6'o15, [6'o20:6'o27], 6'o32, 6'o40, 6'o41, 6'o42};
   endfunction

   function automatic bit is_br(input logic [5:0] u);
      return u inside {6'o30, 6'o31, [6'o34:6'o37]};
   endfunction

   task automatic model_reset();
      m_sq = 0; m_halt = 0; m_ret = 0;
      e_wren = 0; e_redir = 0; e_exc = 0; e_squash = 0;
      e_wridx = 0; e_wrdata = 0; e_target = 0;
   endtask

   // Applies the spec rules to the instruction sampled at this edge.
   task automatic model_edge(input bit v, input logic [5:0] u, input logic [4:0] rd,
                             input logic [31:0] p, input logic [31:0] r, input logic [31:0] b);
      bit          tk;
      logic [31:0] seq;
      e_wren = 0; e_redir = 0; e_exc = 0; e_wridx = 0; e_wrdata = 0; e_target = 0;
      seq = p + 32'd4;
      tk  = (u == U_JAL) || (u == U_JALR) || (is_br(u) && (b != seq));
      if (m_sq > 0) m_sq--;
      else if (v && !m_halt) begin
         if (TRAP && tk && (b % 4 != 0)) begin
            e_exc = 1; m_halt = 1;
         end else begin
            m_ret = m_ret + 32'd1;
            if (is_wr(u) && rd != 0) begin e_wren = 1; e_wridx = rd; e_wrdata = r; end
            if (tk) begin e_redir = 1; e_target = b & 32'hFFFF_FFFC; m_sq = D; end
         end
      end
      e_squash = (m_sq > 0);
   endtask

   task automatic step(input bit v, input logic [5:0] u, input logic [4:0] rd,
                       input logic [31:0] p, input logic [31:0] r, input logic [31:0] b);
      valid = v; uops = u; rd_idx = rd; pc = p; rd1 = r; br = b;
      @(posedge clk);
      model_edge(v, u, rd, p, r, b);
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, U_ADD, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      valid = 0; uops = 0; rd_idx = 0; pc = 0; rd1 = 0; br = 0;
      rst = 1;
      model_reset();
      #12;
      checks++; if (wr_en !== 1'b0)      begin errors++; $display("FAIL reset_wren got %b exp 0", wr_en); end
      checks++; if (wr_idx !== 5'd0)     begin errors++; $display("FAIL reset_wridx got %h exp 0", wr_idx); end
      checks++; if (wr_data !== 32'd0)   begin errors++; $display("FAIL reset_wrdata got %h exp 0", wr_data); end
      checks++; if (redirect !== 1'b0)   begin errors++; $display("FAIL reset_redirect got %b exp 0", redirect); end
      checks++; if (target !== 32'd0)    begin errors++; $display("FAIL reset_target got %h exp 0", target); end
      checks++; if (squash !== 1'b0)     begin errors++; $display("FAIL reset_squash got %b exp 0", squash); end
      checks++; if (exc !== 1'b0)        begin errors++; $display("FAIL reset_exc got %b exp 0", exc); end
      checks++; if (retired !== 32'd0)   begin errors++; $display("FAIL reset_retired got %h exp 0", retired); end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_add_write();
      step(1, U_ADD, 5, 32'h0, 32'h1234, 32'h4);
      checks++; if (wr_en !== 1'b1)        begin errors++; $display("FAIL add_wren got %b exp 1", wr_en); end
      checks++; if (wr_idx !== 5'd5)       begin errors++; $display("FAIL add_wridx got %0d exp 5", wr_idx); end
      checks++; if (wr_data !== 32'h1234)  begin errors++; $display("FAIL add_wrdata got %h exp 1234", wr_data); end
      checks++; if (retired !== 32'd1)     begin errors++; $display("FAIL add_retired got %0d exp 1", retired); end
   endtask

   task automatic test_branch_not_taken();
      step(1, U_BEQ, 7, 32'h100, 32'hDEAD, 32'h104);
      checks++; if (redirect !== 1'b0)     begin errors++; $display("FAIL bnt_redirect got %b exp 0", redirect); end
      checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL bnt_wren got %b exp 0", wr_en); end
      checks++; if (retired !== m_ret)     begin errors++; $display("FAIL bnt_retired got %0d exp %0d", retired, m_ret); end
   endtask

   task automatic test_taken_squash();
      logic [31:0] r0;
      r0 = m_ret;
      step(1, U_BNE, 0, 32'h100, 32'h0, 32'h0F0);
      checks++; if (redirect !== 1'b1)     begin errors++; $display("FAIL tk_redirect got %b exp 1", redirect); end
      checks++; if (target !== 32'h0F0)    begin errors++; $display("FAIL tk_target got %h exp 0f0", target); end
      checks++; if (squash !== 1'b1)       begin errors++; $display("FAIL tk_squash0 got %b exp 1", squash); end
      step(1, U_ADD, 6, 32'h104, 32'h66, 32'h108);
      checks++; if (wr_en !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL tk_add1 wren=%b redirect=%b exp 0 0", wr_en, redirect); end
      checks++; if (squash !== 1'b1)       begin errors++; $display("FAIL tk_squash1 got %b exp 1", squash); end
      step(1, U_ADD, 7, 32'h108, 32'h77, 32'h10C);
      checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL tk_add2_wren got %b exp 0", wr_en); end
      checks++; if (squash !== 1'b0)       begin errors++; $display("FAIL tk_squash2 got %b exp 0", squash); end
      step(1, U_ADD, 8, 32'h10C, 32'h88, 32'h110);
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd8 || wr_data !== 32'h88)
         begin errors++; $display("FAIL tk_add3 got wren=%b idx=%0d data=%h exp 1 8 88", wr_en, wr_idx, wr_data); end
      checks++; if (retired !== r0 + 32'd2) begin errors++; $display("FAIL tk_retired got %0d exp %0d", retired, r0 + 32'd2); end
   endtask

   task automatic test_jal_auipc();
      step(1, U_JAL, 1, 32'h100, 32'h104, 32'h200);
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd1 || wr_data !== 32'h104)
         begin errors++; $display("FAIL jal_write got wren=%b idx=%0d data=%h exp 1 1 104", wr_en, wr_idx, wr_data); end
      checks++; if (redirect !== 1'b1 || target !== 32'h200)
         begin errors++; $display("FAIL jal_redirect got %b target=%h exp 1 200", redirect, target); end
      idle(); idle();
      step(1, U_AUIPC, 3, 32'h1000, 32'h3000, 32'h3000);
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd3 || wr_data !== 32'h3000)
         begin errors++; $display("FAIL auipc_write got wren=%b idx=%0d data=%h exp 1 3 3000", wr_en, wr_idx, wr_data); end
      checks++; if (redirect !== 1'b0)     begin errors++; $display("FAIL auipc_redirect got %b exp 0", redirect); end
   endtask

   task automatic test_rd0_wrap();
      logic [31:0] r0;
      r0 = m_ret;
      step(1, U_ADD, 0, 32'h40, 32'h55, 32'h44);
      checks++; if (wr_en !== 1'b0)        begin errors++; $display("FAIL rd0_wren got %b exp 0", wr_en); end
      checks++; if (retired !== r0 + 32'd1) begin errors++; $display("FAIL rd0_retired got %0d exp %0d", retired, r0 + 32'd1); end
      force dut.retired_q = 32'hFFFF_FFFF;
      m_ret = 32'hFFFF_FFFF;
      idle();
      release dut.retired_q;
      step(1, U_ADD, 2, 32'h48, 32'h1, 32'h4C);
      checks++; if (retired !== 32'd0)     begin errors++; $display("FAIL wrap_retired got %h exp 0", retired); end
   endtask

   task automatic test_reset_mid_squash();
      step(1, U_JALR, 4, 32'h500, 32'h504, 32'h800);
      #2 rst = 1;
      model_reset();
      #1;
      checks++; if (squash !== 1'b0 || redirect !== 1'b0 || wr_en !== 1'b0 || retired !== 32'd0)
         begin errors++; $display("FAIL rstmid_outs got squash=%b redirect=%b wren=%b retired=%0d exp 0 0 0 0", squash, redirect, wr_en, retired); end
      @(negedge clk);
      rst = 0;
      step(1, U_ADD, 9, 32'h600, 32'h99, 32'h604);
      checks++; if (wr_en !== 1'b1 || wr_idx !== 5'd9 || wr_data !== 32'h99)
         begin errors++; $display("FAIL rstmid_add got wren=%b idx=%0d data=%h exp 1 9 99", wr_en, wr_idx, wr_data); end
      checks++; if (retired !== 32'd1)     begin errors++; $display("FAIL rstmid_retired got %0d exp 1", retired); end
   endtask

   task automatic test_random();
      logic [5:0]  pool [12] = '{6'o00, 6'o05, 6'o14, 6'o20, 6'o32, 6'o30, 6'o31, 6'o34, 6'o37,
                                 6'o40, 6'o41, 6'o42};
      logic [5:0]  u;
      logic [31:0] p, b;
      bit          v;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 4) != 0);
         u = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
         p = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 0) b = p + 32'd4;
         else b = $urandom;
         if (TRAP) b = b & 32'hFFFF_FFFC;
         step(v, u, 5'($urandom), p, $urandom, b);
         checks++; if (wr_en !== e_wren) begin errors++; $display("FAIL rnd_wren cyc %0d got %b exp %b", i, wr_en, e_wren); end
         if (e_wren) begin
            checks++;
            if (wr_idx !== e_wridx || wr_data !== e_wrdata)
               begin errors++; $display("FAIL rnd_wdata cyc %0d got %0d/%h exp %0d/%h", i, wr_idx, wr_data, e_wridx, e_wrdata); end
         end
         checks++; if (redirect !== e_redir) begin errors++; $display("FAIL rnd_redirect cyc %0d got %b exp %b", i, redirect, e_redir); end
         if (e_redir) begin
            checks++; if (target !== e_target) begin errors++; $display("FAIL rnd_target cyc %0d got %h exp %h", i, target, e_target); end
         end
         checks++; if (squash !== e_squash) begin errors++; $display("FAIL rnd_squash cyc %0d got %b exp %b", i, squash, e_squash); end
         checks++; if (exc !== e_exc) begin errors++; $display("FAIL rnd_exc cyc %0d got %b exp %b", i, exc, e_exc); end
         checks++; if (retired !== m_ret) begin errors++; $display("FAIL rnd_retired cyc %0d got %0d exp %0d", i, retired, m_ret); end
      end
   endtask

   task automatic test_misalign();
      logic [31:0] r0;
      idle(); idle(); idle();
      r0 = m_ret;
      step(1, U_JALR, 1, 32'h100, 32'h104, 32'h102);
`ifdef WB_MISALIGN_TRAP_EN
      checks++; if (exc !== 1'b1 || wr_en !== 1'b0 || redirect !== 1'b0)
         begin errors++; $display("FAIL mis_trap got exc=%b wren=%b redirect=%b exp 1 0 0", exc, wr_en, redirect); end
      step(1, U_ADD, 5, 32'h104, 32'h5, 32'h108);
      checks++; if (wr_en !== 1'b0 || exc !== 1'b0 || retired !== r0)
         begin errors++; $display("FAIL mis_halt got wren=%b exc=%b retired=%0d exp 0 0 %0d", wr_en, exc, retired, r0); end
`else
      checks++; if (exc !== 1'b0 || redirect !== 1'b1 || target !== 32'h100 || wr_en !== 1'b1)
         begin errors++; $display("FAIL mis_force got exc=%b redirect=%b target=%h wren=%b exp 0 1 100 1", exc, redirect, target, wr_en); end
      checks++; if (retired !== r0 + 32'd1) begin errors++; $display("FAIL mis_retired got %0d exp %0d", retired, r0 + 32'd1); end
`endif
   endtask

   initial begin
      test_reset();
      test_add_write();
      test_branch_not_taken();
      test_taken_squash();
      test_jal_auipc();
      test_rd0_wrap();
      test_reset_mid_squash();
      test_random();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
